// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory-bus interface unit: FSM encoding,
// arbitration mode constants and port-index width helper.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } bus_state_e;

  localparam int unsigned ARB_FIXED = 32'd0;
  localparam int unsigned ARB_RR    = 32'd1;

  // Read-latency counter covers 1..7.
  localparam int unsigned          CNT_W   = 32'd3;
  localparam logic [CNT_W-1:0]     CNT_ONE = 3'd1;

  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_bus_unit_arbiter.sv
// Request arbiter: combinational winner selection (fixed priority or
// round-robin) with a registered round-robin pointer.
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter  int unsigned NPORTS   = 2,
  parameter  int unsigned ARB_MODE = ARB_FIXED,
  localparam int unsigned IW       = port_idx_w(NPORTS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NPORTS-1:0] req_i,
  input  logic              update_i,
  output logic              any_o,
  output logic [NPORTS-1:0] win_oh_o,
  output logic [IW-1:0]     win_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  int unsigned   cand_s;

  // Winner search: fixed mode scans from port 0, round-robin starts after the pointer.
  always_comb begin
    any_o     = 1'b0;
    win_oh_o  = '0;
    win_idx_o = '0;
    cand_s    = 32'd0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (ARB_MODE == ARB_RR) begin
        cand_s = (32'(ptr_q) + 32'd1 + k) % NPORTS;
      end else begin
        cand_s = k;
      end
      if (!any_o && req_i[IW'(cand_s)]) begin
        any_o                    = 1'b1;
        win_idx_o                = IW'(cand_s);
        win_oh_o[IW'(cand_s)]    = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

  // Pointer follows the most recent grant.
  always_comb begin
    if (update_i) begin
      ptr_d = win_idx_o;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset value makes port 0 the first round-robin winner.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= IW'(NPORTS - 32'd1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cpu_bus_unit.sv
// Memory-bus interface unit: arbitrates NPORTS requesters onto a single
// synchronous memory port, one transaction outstanding at a time.
module cpu_bus_unit
  import cpu_bus_pkg::*;
#(
  parameter int unsigned NPORTS     = 2,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ARB_MODE   = ARB_FIXED
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [NPORTS-1:0]        iReq,
  input  logic [NPORTS-1:0]        iWe,
  input  logic [NPORTS*DW/8-1:0]   iBE,
  input  logic [NPORTS*AW-1:0]     iAddr,
  input  logic [NPORTS*DW-1:0]     iWData,
  output logic [NPORTS-1:0]        oGnt,
  output logic [NPORTS-1:0]        oAck,
  output logic [DW-1:0]            oRData,
  output logic                     oBusy,
  output logic                     oMemRE,
  output logic                     oMemWE,
  output logic [DW/8-1:0]          oMemBE,
  output logic [AW-1:0]            oMemAddr,
  output logic [DW-1:0]            oMemWData,
  input  logic [DW-1:0]            iMemRData
);

  localparam int unsigned NB = DW / 32'd8;
  localparam int unsigned IW = port_idx_w(NPORTS);

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [NPORTS-1:0] gnt_q, gnt_d;
  logic [NPORTS-1:0] ack_q, ack_d;
  logic [IW-1:0]     port_q, port_d;

  logic              arb_any_s;
  logic              arb_upd_s;
  logic [NPORTS-1:0] arb_oh_s;
  logic [IW-1:0]     arb_idx_s;

  bus_arbiter #(
    .NPORTS   (NPORTS),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk_i     (iCLK),
    .rst_i     (iRST),
    .req_i     (iReq),
    .update_i  (arb_upd_s),
    .any_o     (arb_any_s),
    .win_oh_o  (arb_oh_s),
    .win_idx_o (arb_idx_s)
  );

  // Transaction FSM: grant/latch in IDLE, strobe in ACCESS, count down read latency in WAIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    port_d    = port_q;
    gnt_d     = '0;
    ack_d     = '0;
    arb_upd_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          state_d   = ST_ACCESS;
          we_d      = iWe[arb_idx_s];
          be_d      = iBE[arb_idx_s*NB +: NB];
          addr_d    = iAddr[arb_idx_s*AW +: AW];
          wdata_d   = iWData[arb_idx_s*DW +: DW];
          port_d    = arb_idx_s;
          gnt_d     = arb_oh_s;
          arb_upd_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d        = ST_IDLE;
          ack_d[port_q]  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LATENCY);
        end
      end
      ST_WAIT: begin
        // A count of 1 marks the cycle in which memory data is valid.
        if (cnt_q <= CNT_ONE) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          rdata_d       = iMemRData;
          ack_d[port_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and latched-request registers; reset drops any pending transaction.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      port_q  <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      port_q  <= port_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
    end
  end

  assign oGnt      = gnt_q;
  assign oAck      = ack_q;
  assign oRData    = rdata_q;
  assign oBusy     = (state_q != ST_IDLE);
  assign oMemRE    = (state_q == ST_ACCESS) && !we_q;
  assign oMemWE    = (state_q == ST_ACCESS) && we_q;
  assign oMemBE    = be_q;
  assign oMemAddr  = addr_q;
  assign oMemWData = wdata_q;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Directed bench for cpu_bus_unit: a fixed-priority 2-port instance (latency 1)
// and a round-robin 3-port instance (latency 3), acks checked via scoreboards.
module tb_cpu_bus_unit;

  typedef struct packed {
    logic [2:0]  port;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  exp_t sq_a[$];
  exp_t sq_b[$];

  // Instance A: NPORTS=2, RD_LATENCY=1, fixed priority
  logic        a_rst = 1'b1;
  logic [1:0]  a_req = '0, a_we = '0;
  logic [7:0]  a_be = '0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [1:0]  a_gnt, a_ack;
  logic [31:0] a_rdata, a_maddr, a_mwdata;
  logic [31:0] a_mrdata = '0;
  logic        a_busy, a_re, a_mwe;
  logic [3:0]  a_mbe;

  cpu_bus_unit #(.NPORTS(2), .AW(32), .DW(32), .RD_LATENCY(1), .ARB_MODE(0)) dut_a (
    .iCLK(clk), .iRST(a_rst), .iReq(a_req), .iWe(a_we), .iBE(a_be), .iAddr(a_addr),
    .iWData(a_wdata), .oGnt(a_gnt), .oAck(a_ack), .oRData(a_rdata), .oBusy(a_busy),
    .oMemRE(a_re), .oMemWE(a_mwe), .oMemBE(a_mbe), .oMemAddr(a_maddr),
    .oMemWData(a_mwdata), .iMemRData(a_mrdata)
  );

  // Instance B: NPORTS=3, RD_LATENCY=3, round-robin
  logic        b_rst = 1'b1;
  logic [2:0]  b_req = '0, b_we = '0;
  logic [11:0] b_be = '0;
  logic [95:0] b_addr = '0, b_wdata = '0;
  logic [2:0]  b_gnt, b_ack;
  logic [31:0] b_rdata, b_maddr, b_mwdata;
  logic [31:0] b_mrdata = '0;
  logic        b_busy, b_re, b_mwe;
  logic [3:0]  b_mbe;

  cpu_bus_unit #(.NPORTS(3), .AW(32), .DW(32), .RD_LATENCY(3), .ARB_MODE(1)) dut_b (
    .iCLK(clk), .iRST(b_rst), .iReq(b_req), .iWe(b_we), .iBE(b_be), .iAddr(b_addr),
    .iWData(b_wdata), .oGnt(b_gnt), .oAck(b_ack), .oRData(b_rdata), .oBusy(b_busy),
    .oMemRE(b_re), .oMemWE(b_mwe), .oMemBE(b_mbe), .oMemAddr(b_maddr),
    .oMemWData(b_mwdata), .iMemRData(b_mrdata)
  );

  function automatic exp_t mk(input int p, input logic rd, input logic [31:0] d);
    exp_t e;
    e.port = 3'(p);
    e.rd   = rd;
    e.data = d;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge and retire any ack against the scoreboards.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (a_ack != 2'b00) begin
      if (sq_a.size() == 0) begin
        chk("a_ack_unexpected", 64'(a_ack), 64'd0);
      end else begin
        e = sq_a.pop_front();
        chk("a_ack_port", 64'(a_ack), 64'(8'd1 << e.port));
        if (e.rd) chk("a_ack_rdata", 64'(a_rdata), 64'(e.data));
      end
    end
    if (b_ack != 3'b000) begin
      if (sq_b.size() == 0) begin
        chk("b_ack_unexpected", 64'(b_ack), 64'd0);
      end else begin
        e = sq_b.pop_front();
        chk("b_ack_port", 64'(b_ack), 64'(8'd1 << e.port));
        if (e.rd) chk("b_ack_rdata", 64'(b_rdata), 64'(e.data));
      end
    end
  endtask

  initial begin
    // Reset state of both instances
    step();
    step();
    chk("a_rst_outs", {a_gnt, a_ack, a_busy, a_re, a_mwe, a_mbe, a_maddr}, 64'd0);
    chk("a_rst_data", {a_rdata, a_mwdata}, 64'd0);
    chk("b_rst_outs", {b_gnt, b_ack, b_busy, b_re, b_mwe, b_mbe, b_maddr}, 64'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    step();

    // A: port 0 write
    a_req = 2'b01; a_we = 2'b01; a_be[3:0] = 4'hF;
    a_addr[31:0] = 32'h1001_0000; a_wdata[31:0] = 32'hCAFE_BABE;
    sq_a.push_back(mk(0, 1'b0, 32'd0));
    step();
    chk("a_wr_c1_gnt", 64'(a_gnt), 64'd1);
    chk("a_wr_c1_strobes", {62'd0, a_mwe, a_re}, 64'd2);
    chk("a_wr_c1_bus", {a_maddr, a_mwdata}, 64'h1001_0000_CAFE_BABE);
    chk("a_wr_c1_be", 64'(a_mbe), 64'hF);
    a_req = 2'b00;
    step();
    chk("a_wr_c2_ack", 64'(a_ack), 64'd1);
    chk("a_wr_c2_we_low", {62'd0, a_mwe, a_gnt[0]}, 64'd0);
    step();

    // A: port 1 read, latency 1
    a_req = 2'b10; a_we = 2'b00; a_be[7:4] = 4'hF; a_addr[63:32] = 32'h0040_0004;
    sq_a.push_back(mk(1, 1'b1, 32'hDEAD_BEEF));
    step();
    chk("a_rd_c1_gnt", 64'(a_gnt), 64'd2);
    chk("a_rd_c1_re", {62'd0, a_re, a_mwe}, 64'd2);
    chk("a_rd_c1_addr", 64'(a_maddr), 64'h0040_0004);
    a_req = 2'b00;
    step();
    a_mrdata = 32'hDEAD_BEEF;
    chk("a_rd_c2_re_low", {61'd0, a_re, a_ack}, 64'd0);
    chk("a_rd_c2_busy", 64'(a_busy), 64'd1);
    step();
    chk("a_rd_c3_ack", 64'(a_ack), 64'd2);
    a_mrdata = 32'h0;
    step();

    // A: fixed priority with both ports requesting writes
    a_req = 2'b11; a_we = 2'b11; a_be = 8'hFF;
    a_addr = {32'h0000_2000, 32'h0000_1000}; a_wdata = {32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 3; k++) begin
      sq_a.push_back(mk(0, 1'b0, 32'd0));
      step();
      chk("a_fix_gnt0", 64'(a_gnt), 64'd1);
      step();
    end
    a_req = 2'b10;
    sq_a.push_back(mk(1, 1'b0, 32'd0));
    step();
    chk("a_fix_gnt1", 64'(a_gnt), 64'd2);
    chk("a_fix_bus1", {a_maddr, a_mwdata}, 64'h0000_2000_2222_2222);
    a_req = 2'b00;
    step();
    chk("a_rdata_held", 64'(a_rdata), 64'hDEAD_BEEF);
    step();

    // A: zero byte enables still run a full write
    a_req = 2'b01; a_be[3:0] = 4'h0;
    sq_a.push_back(mk(0, 1'b0, 32'd0));
    step();
    chk("a_be0_c1", {59'd0, a_mwe, a_mbe}, 64'h10);
    a_req = 2'b00;
    step();
    chk("a_be0_c2_ack", 64'(a_ack), 64'd1);

    // B: round-robin, all three ports writing continuously
    b_req = 3'b111; b_we = 3'b111; b_be = 12'hFFF;
    b_addr = {32'h300, 32'h200, 32'h100};
    for (int k = 0; k < 5; k++) begin
      sq_b.push_back(mk(k % 3, 1'b0, 32'd0));
      step();
      chk("b_rr_gnt", 64'(b_gnt), 64'(3'd1 << (k % 3)));
      if (k == 4) b_req = 3'b000;
      step();
    end
    step();

    // B: port 2 read, latency 3, data valid only in the sampling cycle
    b_req = 3'b100; b_we = 3'b000; b_addr[95:64] = 32'h0000_0800; b_mrdata = 32'h1111_1111;
    sq_b.push_back(mk(2, 1'b1, 32'hA5A5_0003));
    step();
    chk("b_rd_c1_gnt", 64'(b_gnt), 64'd4);
    chk("b_rd_c1_re", 64'(b_re), 64'd1);
    b_req = 3'b000;
    step();
    chk("b_rd_c2_rdata", {31'd0, b_re, b_rdata}, 64'd0);
    step();
    chk("b_rd_c3_rdata", {29'd0, b_ack, b_rdata}, 64'd0);
    step();
    b_mrdata = 32'hA5A5_0003;
    chk("b_rd_c4_rdata", {29'd0, b_ack, b_rdata}, 64'd0);
    chk("b_rd_c4_addr", 64'(b_maddr), 64'h800);
    step();
    chk("b_rd_c5_ack", 64'(b_ack), 64'd4);
    b_mrdata = 32'h2222_2222;
    step();

    // B: a following write leaves read data untouched
    b_req = 3'b001; b_we = 3'b001;
    sq_b.push_back(mk(0, 1'b0, 32'd0));
    step();
    chk("b_wr_gnt", 64'(b_gnt), 64'd1);
    b_req = 3'b000;
    step();
    chk("b_wr_rdata_held", 64'(b_rdata), 64'hA5A5_0003);
    step();

    // B: reset during a read WAIT cycle
    b_req = 3'b010; b_we = 3'b000;
    step();
    chk("b_rst_rd_gnt", 64'(b_gnt), 64'd2);
    b_req = 3'b000;
    step();
    chk("b_rst_in_wait", 64'(b_busy), 64'd1);
    b_rst = 1'b1;
    #1;
    chk("b_rst_outs", {b_gnt, b_ack, b_busy, b_re, b_mwe, b_mbe, b_maddr}, 64'd0);
    chk("b_rst_rdata", 64'(b_rdata), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("b_rst_no_ack", {61'd0, b_ack}, 64'd0);
    end
    b_rst = 1'b0;
    b_req = 3'b111; b_we = 3'b111;
    sq_b.push_back(mk(0, 1'b0, 32'd0));
    step();
    chk("b_post_rst_gnt", 64'(b_gnt), 64'd1);
    b_req = 3'b000;
    step();
    step();

    chk("a_sb_empty", 64'(sq_a.size()), 64'd0);
    chk("b_sb_empty", 64'(sq_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
